// File: rtl/fsfifo_ext.sv
// fsfifo_ext: single-clock synchronous FIFO with arbitrary depth,
// optional first-word-fall-through read mode, fill level with
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags.
//
// In FWFT mode rd_data_o is a prefetch register that counts towards
// level_o, so the total capacity is DEPTH words either way. The word RAM
// is never read and written at the same address on the same edge:
// a prefetch load only takes a word that was already stored on an
// earlier edge.

module fsfifo_ext #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       clr_err_i,
    input  logic                       wr_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("fsfifo_ext: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("fsfifo_ext: DEPTH must be >= 2");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fsfifo_ext: FWFT must be 0 or 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fsfifo_ext: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fsfifo_ext: AEMPTY_THRESH out of range 0..DEPTH-1");
    end

    // Advance a pointer with an explicit wrap at DEPTH-1 (depth need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             mem_nonempty_s;
    logic             load_s;

    // Accept decisions, pointer/level/prefetch next state and registered status decode.
    always_comb begin
        wr_acc_s       = wr_i && !full_q && !flush_i;
        rd_acc_s       = rd_i && !empty_q && !flush_i;
        mem_nonempty_s = 1'b0;
        load_s         = 1'b0;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        valid_d        = 1'b0;
        rd_data_d      = rd_data_q;

        // RAM holds level minus the prefetched word (if any).
        if (FWFT != 0) begin
            mem_nonempty_s = (level_q > {{(LW-1){1'b0}}, valid_q});
            load_s         = (!valid_q || rd_acc_s) && mem_nonempty_s && !flush_i;
        end else begin
            mem_nonempty_s = (level_q != '0);
            load_s         = rd_acc_s;
        end

        if (wr_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (load_s) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            rd_data_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d  = rd_ptr_q;
            rd_data_d = rd_data_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (FWFT != 0) begin
            if (load_s) begin
                valid_d = 1'b1;
            end else if (rd_acc_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = 1'b0;
        end

        // Flush wins over any request in the same cycle; rd_data is kept.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_d;
        end

        if (FWFT != 0) begin
            empty_d = !valid_d;
        end else begin
            empty_d = (level_d == '0);
        end
        full_d   = (level_d == LW'(DEPTH));
        afull_d  = (level_d >= LW'(AFULL_THRESH));
        aempty_d = (level_d <= LW'(AEMPTY_THRESH));

        // Sticky error flags: a new event outranks a clear request.
        if (wr_i && full_q && !flush_i) begin
            ovf_d = 1'b1;
        end else if (clr_err_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (rd_i && empty_q && !flush_i) begin
            unf_d = 1'b1;
        end else if (clr_err_i) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Word storage; contents are meaningless once level is reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (wr_acc_s && !reset_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o      = rd_data_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign level_o        = level_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fsfifo_ext.sv
// Testbench for fsfifo_ext: a standard-read instance (DEPTH=5) and an FWFT
// instance (DEPTH=4) share one stimulus stream. Each is compared every
// cycle against a queue-based reference model; directed sequences add
// fixed expected values for latency, wrap, flush and reset cases.

module tb_fsfifo_ext;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       flush_i;
    logic       clr_err_i;
    logic       wr_i;
    logic [7:0] wr_data_i;
    logic       rd_i;

    logic [7:0] std_rd_data, fw_rd_data;
    logic       std_full, std_empty, std_afull, std_aempty, std_ovf, std_unf;
    logic       fw_full, fw_empty, fw_afull, fw_aempty, fw_ovf, fw_unf;
    logic [2:0] std_level, fw_level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    fsfifo_ext #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_std (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .clr_err_i(clr_err_i),
        .wr_i(wr_i), .wr_data_i(wr_data_i), .rd_i(rd_i), .rd_data_o(std_rd_data),
        .full_o(std_full), .empty_o(std_empty), .almost_full_o(std_afull),
        .almost_empty_o(std_aempty), .level_o(std_level),
        .overflow_o(std_ovf), .underflow_o(std_unf)
    );

    fsfifo_ext #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fw (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .clr_err_i(clr_err_i),
        .wr_i(wr_i), .wr_data_i(wr_data_i), .rd_i(rd_i), .rd_data_o(fw_rd_data),
        .full_o(fw_full), .empty_o(fw_empty), .almost_full_o(fw_afull),
        .almost_empty_o(fw_aempty), .level_o(fw_level),
        .overflow_o(fw_ovf), .underflow_o(fw_unf)
    );

    // Reference model state.
    typedef struct {
        logic [7:0]  d;
        int unsigned e;
    } ent_t;

    int unsigned ecnt = 0;
    logic [7:0]  qs[$];
    logic [7:0]  rds;
    bit          ovs, uns;
    ent_t        qf[$];
    logic [7:0]  rdf;
    bit          ovfm, unfm, visf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qs.delete();
        qf.delete();
        rds  = 8'h00;
        rdf  = 8'h00;
        ovs  = 1'b0;
        uns  = 1'b0;
        ovfm = 1'b0;
        unfm = 1'b0;
        visf = 1'b0;
    endtask

    // One clock edge of both FIFOs, from the specified rules.
    // FWFT head word is visible once it was stored before the latest edge.
    task automatic model_step();
        bit   s_full, s_emp, f_full;
        ent_t en;
        ecnt++;
        if (reset_i) begin
            model_reset();
            return;
        end
        s_full = (qs.size() == 5);
        s_emp  = (qs.size() == 0);
        f_full = (qf.size() == 4);
        if (wr_i && s_full && !flush_i) ovs = 1'b1; else if (clr_err_i) ovs = 1'b0;
        if (rd_i && s_emp && !flush_i)  uns = 1'b1; else if (clr_err_i) uns = 1'b0;
        if (wr_i && f_full && !flush_i) ovfm = 1'b1; else if (clr_err_i) ovfm = 1'b0;
        if (rd_i && !visf && !flush_i)  unfm = 1'b1; else if (clr_err_i) unfm = 1'b0;
        if (flush_i) begin
            qs.delete();
            qf.delete();
        end else begin
            if (rd_i && !s_emp) rds = qs.pop_front();
            if (wr_i && !s_full) qs.push_back(wr_data_i);
            if (rd_i && visf) en = qf.pop_front();
            if (wr_i && !f_full) begin
                en.d = wr_data_i;
                en.e = ecnt;
                qf.push_back(en);
            end
        end
        visf = (qf.size() > 0) && (qf[0].e < ecnt);
        if (visf) rdf = qf[0].d;
    endtask

    task automatic compare_all();
        chk("std_level",  64'(std_level),  64'(qs.size()));
        chk("std_empty",  64'(std_empty),  64'(qs.size() == 0));
        chk("std_full",   64'(std_full),   64'(qs.size() == 5));
        chk("std_afull",  64'(std_afull),  64'(qs.size() >= 3));
        chk("std_aempty", 64'(std_aempty), 64'(qs.size() <= 2));
        chk("std_ovf",    64'(std_ovf),    64'(ovs));
        chk("std_unf",    64'(std_unf),    64'(uns));
        chk("std_data",   64'(std_rd_data), 64'(rds));
        chk("fw_level",   64'(fw_level),   64'(qf.size()));
        chk("fw_empty",   64'(fw_empty),   64'(!visf));
        chk("fw_full",    64'(fw_full),    64'(qf.size() == 4));
        chk("fw_afull",   64'(fw_afull),   64'(qf.size() >= 2));
        chk("fw_aempty",  64'(fw_aempty),  64'(qf.size() <= 2));
        chk("fw_ovf",     64'(fw_ovf),     64'(ovfm));
        chk("fw_unf",     64'(fw_unf),     64'(unfm));
        chk("fw_data",    64'(fw_rd_data), 64'(rdf));
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic idle();
        wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
    endtask

    task automatic clean();
        idle();
        flush_i = 1'b1; clr_err_i = 1'b1;
        cycle();
        idle();
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        wr_data_i = 8'h00;
        model_reset();
        repeat (2) cycle();
        chk("rst_level", 64'(std_level), 64'd0);
        chk("rst_empty", 64'(std_empty), 64'd1);
        reset_i = 1'b0;
        cycle();

        // Fill the DEPTH=5 FIFO, then drain it in order.
        for (int i = 0; i < 5; i++) begin
            wr_i = 1'b1; wr_data_i = 8'(8'h11 * (i + 1));
            cycle();
            if (i == 2) chk("afull_at3", 64'(std_afull), 64'd1);
        end
        idle();
        chk("fill_full", 64'(std_full), 64'd1);
        chk("fill_level", 64'(std_level), 64'd5);
        for (int i = 0; i < 5; i++) begin
            rd_i = 1'b1;
            cycle();
            chk("drain_data", 64'(std_rd_data), 64'(8'(8'h11 * (i + 1))));
        end
        idle();
        chk("drain_empty", 64'(std_empty), 64'd1);
        clean();

        // Full with simultaneous write and read: write rejected.
        for (int i = 0; i < 5; i++) begin
            wr_i = 1'b1; wr_data_i = 8'(8'h60 + i);
            cycle();
        end
        wr_i = 1'b1; rd_i = 1'b1; wr_data_i = 8'hEE;
        cycle();
        idle();
        chk("ovf_level", 64'(std_level), 64'd4);
        chk("ovf_set", 64'(std_ovf), 64'd1);
        clr_err_i = 1'b1;
        cycle();
        idle();
        chk("ovf_clr", 64'(std_ovf), 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd_i = 1'b1;
            cycle();
        end
        chk("rd_last", 64'(std_rd_data), 64'h64);
        cycle();
        idle();
        chk("unf_set", 64'(std_unf), 64'd1);
        chk("unf_level", 64'(std_level), 64'd0);
        clean();

        // FWFT single-word latency.
        wr_i = 1'b1; wr_data_i = 8'hA5;
        cycle();
        idle();
        chk("fw_lvl_n1", 64'(fw_level), 64'd1);
        chk("fw_emp_n1", 64'(fw_empty), 64'd1);
        cycle();
        chk("fw_dat_n2", 64'(fw_rd_data), 64'hA5);
        chk("fw_emp_n2", 64'(fw_empty), 64'd0);
        rd_i = 1'b1;
        cycle();
        idle();
        chk("fw_pop_emp", 64'(fw_empty), 64'd1);
        clean();

        // FWFT streaming at full rate: 20 words, no gaps after the fill latency.
        for (int k = 0; k < 22; k++) begin
            wr_i = (k < 20); wr_data_i = 8'(k);
            rd_i = (k >= 2);
            if (k >= 2) begin
                chk("stream_data", 64'(fw_rd_data), 64'(k - 2));
                chk("stream_valid", 64'(fw_empty), 64'd0);
            end
            cycle();
        end
        idle();
        chk("stream_ovf", 64'(fw_ovf), 64'd0);
        chk("stream_unf", 64'(fw_unf), 64'd0);
        chk("stream_end", 64'(fw_empty), 64'd1);
        clean();

        // Wrap-around through pointer value 4 -> 0 twice on DEPTH=5.
        for (int i = 0; i < 13; i++) begin
            wr_i = 1'b1; wr_data_i = 8'(i * 7 + 3);
            cycle();
            idle();
            chk("wrap_lvl", 64'(std_level <= 3'd1), 64'd1);
            rd_i = 1'b1;
            cycle();
            idle();
            chk("wrap_data", 64'(std_rd_data), 64'(8'(i * 7 + 3)));
        end
        clean();

        // Flush at level 3 with requests pending.
        for (int i = 0; i < 3; i++) begin
            wr_i = 1'b1; wr_data_i = 8'(8'h30 + i);
            cycle();
        end
        wr_i = 1'b1; rd_i = 1'b1; flush_i = 1'b1;
        cycle();
        idle();
        chk("flush_lvl", 64'(std_level), 64'd0);
        chk("flush_emp", 64'(std_empty), 64'd1);
        chk("flush_fwlvl", 64'(fw_level), 64'd0);
        chk("flush_err", 64'({std_ovf, std_unf, fw_ovf, fw_unf}), 64'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) begin
            wr_i = 1'b1; wr_data_i = 8'(8'h70 + i);
            cycle();
        end
        #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        chk("arst_lvl", 64'(std_level), 64'd0);
        chk("arst_emp", 64'(std_empty), 64'd1);
        chk("arst_data", 64'(std_rd_data), 64'd0);
        chk("arst_fwlvl", 64'(fw_level), 64'd0);
        chk("arst_fwemp", 64'(fw_empty), 64'd1);
        compare_all();
        cycle();
        reset_i = 1'b0;
        idle();
        cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            wr_i      = ($urandom_range(0, 99) < 60);
            rd_i      = ($urandom_range(0, 99) < 50);
            flush_i   = ($urandom_range(0, 99) < 3);
            clr_err_i = ($urandom_range(0, 99) < 6);
            wr_data_i = 8'($urandom);
            cycle();
        end
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
